// File: rtl/idelay_tap_cal_pkg.sv
// Shared types for the IDELAYE2 tap calibration initiator: FSM states, tap limits
// and the window record used by the sweep bookkeeping.
package idelay_tap_cal_pkg;

  localparam int              TAP_W   = 5;
  localparam logic [TAP_W-1:0] TAP_MAX = 5'd31;

  typedef enum logic [3:0] {
    WAIT_RDY, IDLE, LOAD, SETTLE, CHECK, EVAL, FINAL, APPLY, DONE
  } idelay_cal_state_t;

  // len is one bit wider than start so a full 32-tap window is representable
  typedef struct packed {
    logic [TAP_W-1:0] start;
    logic [TAP_W:0]   len;
  } win_t;

endpackage

// File: rtl/idelay_tap_cal_if.sv
// Delay-line and receive-data bundle between the calibrator (master) and the
// IDELAYE2 wrapper / deserializer side (slave).
interface idelay_tap_cal_if #(
  parameter int DW = 8
);
  import idelay_tap_cal_pkg::*;

  logic             ld;
  logic [TAP_W-1:0] cntvaluein;
  logic             ce;
  logic             inc;
  logic             tap_mis;      // debug: readback disagrees with applied tap
  logic             rdy;
  logic [TAP_W-1:0] cntvalueout;
  logic             din_vld;
  logic [DW-1:0]    din;

  modport master (
    output ld, cntvaluein, ce, inc, tap_mis,
    input  rdy, cntvalueout, din_vld, din
  );

  modport slave (
    input  ld, cntvaluein, ce, inc, tap_mis,
    output rdy, cntvalueout, din_vld, din
  );

endinterface

// File: rtl/idelay_tap_cal_win_track.sv
// Passing-window bookkeeping for the tap sweep: tracks the open run of passing
// taps, keeps the earliest widest one, and derives its centre tap.
module idelay_win_track
  import idelay_tap_cal_pkg::*;
#(
  parameter int MIN_WIN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             upd,
  input  logic             close,
  input  logic             pass,
  input  logic [TAP_W-1:0] tap,
  output logic [TAP_W:0]   best_len,
  output logic [TAP_W-1:0] centre
);

  win_t cur, best;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cur  <= '0;
      best <= '0;
    end else if (upd && pass) begin
      if (cur.len == '0) cur.start <= tap;
      cur.len <= cur.len + 1'b1;
    end else if (upd || close) begin
      // strictly greater: on a tie the earlier window stays
      if (cur.len > best.len) best <= cur;
      cur.len <= '0;
    end
  end

  assign best_len = best.len;

  // 5-bit sum equals the 6-bit sum truncated, and never exceeds 31 for a real window
  always_comb begin
    centre = best.start + TAP_W'((best.len - 1'b1) >> 1);
    if (best.len < (TAP_W+1)'(MIN_WIN)) centre = '0;
  end

endmodule

// File: rtl/idelay_tap_cal.sv
// IDELAYE2 tap calibration: sweeps all taps against a training word, loads the
// centre of the widest passing window, then allows single-tap trim.
module idelay_tap_cal
  import idelay_tap_cal_pkg::*;
#(
  parameter int            DW            = 8,
  parameter logic [DW-1:0] TRAIN_PATTERN = 8'hA5,
  parameter int            SETTLE_CYC    = 16,
  parameter int            SAMPLES       = 64,
  parameter int            TIMEOUT       = 1024,
  parameter int            MIN_WIN       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step_up,
  input  logic             step_dn,
  idelay_tap_cal_if.master dl,
  output logic             busy,
  output logic             cal_done,
  output logic             cal_fail,
  output logic [TAP_W-1:0] best_tap,
  output logic [TAP_W:0]   win_len,
  output logic [TAP_W-1:0] tap_cur
);

  localparam int CW = $clog2((SETTLE_CYC > TIMEOUT ? SETTLE_CYC : TIMEOUT) + 1);
  localparam int SW = $clog2(SAMPLES + 1);

  idelay_cal_state_t state;
  logic [TAP_W-1:0]  tap;
  logic [CW-1:0]     cnt;
  logic [SW-1:0]     nsamp;
  logic              fail_q;
  logic              abort, go;
  logic [TAP_W:0]    best_len;
  logic [TAP_W-1:0]  centre;

  assign abort = (state != WAIT_RDY) && !dl.rdy;
  assign go    = start && (state == IDLE || state == DONE);

  idelay_win_track #(.MIN_WIN(MIN_WIN)) u_win (
    .clk     (clk),
    .rst     (rst),
    .clr     (abort || go),
    .upd     (state == EVAL),
    .close   (state == FINAL),
    .pass    (!fail_q),
    .tap     (tap),
    .best_len(best_len),
    .centre  (centre)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= WAIT_RDY;
      tap           <= '0;
      cnt           <= '0;
      nsamp         <= '0;
      fail_q        <= 1'b0;
      dl.ld         <= 1'b0;
      dl.cntvaluein <= '0;
      dl.ce         <= 1'b0;
      dl.inc        <= 1'b0;
      dl.tap_mis    <= 1'b0;
      busy          <= 1'b0;
      cal_done      <= 1'b0;
      cal_fail      <= 1'b0;
      best_tap      <= '0;
      win_len       <= '0;
      tap_cur       <= '0;
    end else begin
      dl.ld      <= 1'b0;
      dl.ce      <= 1'b0;
      dl.inc     <= 1'b0;
      dl.tap_mis <= (state == CHECK || state == DONE) && (dl.cntvalueout != tap_cur);
      if (abort) begin
        state    <= WAIT_RDY;
        busy     <= 1'b0;
        cal_done <= 1'b0;
        cal_fail <= 1'b0;
      end else if (go) begin
        state    <= LOAD;
        tap      <= '0;
        busy     <= 1'b1;
        cal_done <= 1'b0;
        cal_fail <= 1'b0;
      end else begin
        unique case (state)
          WAIT_RDY: state <= IDLE;
          IDLE:     ;
          LOAD: begin
            dl.ld         <= 1'b1;
            dl.cntvaluein <= tap;
            tap_cur       <= tap;
            cnt           <= '0;
            state         <= SETTLE;
          end
          SETTLE: begin
            if (cnt == CW'(SETTLE_CYC - 1)) begin
              cnt    <= '0;
              nsamp  <= '0;
              fail_q <= 1'b0;
              state  <= CHECK;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          CHECK: begin
            cnt <= cnt + 1'b1;
            if (dl.din_vld) begin
              if (dl.din != TRAIN_PATTERN) fail_q <= 1'b1;
              nsamp <= nsamp + 1'b1;
            end
            // a full sample set wins over a timeout landing on the same cycle
            if (dl.din_vld && nsamp == SW'(SAMPLES - 1)) begin
              state <= EVAL;
            end else if (cnt == CW'(TIMEOUT - 1)) begin
              fail_q <= 1'b1;
              state  <= EVAL;
            end
          end
          EVAL: begin
            if (tap == TAP_MAX) begin
              state <= FINAL;
            end else begin
              tap   <= tap + 1'b1;
              state <= LOAD;
            end
          end
          FINAL: state <= APPLY;
          APPLY: begin
            dl.ld         <= 1'b1;
            dl.cntvaluein <= centre;
            best_tap      <= centre;
            win_len       <= best_len;
            tap_cur       <= centre;
            cal_fail      <= best_len < (TAP_W+1)'(MIN_WIN);
            cal_done      <= 1'b1;
            busy          <= 1'b0;
            state         <= DONE;
          end
          DONE: begin
            // ce high this cycle means a step was just taken; hold off one cycle
            if (!dl.ce && (step_up != step_dn)) begin
              if (step_up && tap_cur != TAP_MAX) begin
                dl.ce   <= 1'b1;
                dl.inc  <= 1'b1;
                tap_cur <= tap_cur + 1'b1;
              end else if (step_dn && tap_cur != '0) begin
                dl.ce   <= 1'b1;
                tap_cur <= tap_cur - 1'b1;
              end
            end
          end
          default: state <= WAIT_RDY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_idelay_tap_cal.sv
// Directed bench for idelay_tap_cal: behavioural delay line returning the training
// word only on masked taps, table of sweep scenarios, then trim and rdy-abort sequences.
`timescale 1ns/1ps
module tb_idelay_tap_cal;

  localparam int         DW  = 8;
  localparam logic [7:0] PAT = 8'hA5;

  logic       clk = 1'b0, rst = 1'b1, start = 1'b0, step_up = 1'b0, step_dn = 1'b0;
  logic       rdy_q = 1'b0, vld_en = 1'b0;
  logic [31:0] mask = '0;
  logic       busy, cal_done, cal_fail;
  logic [4:0] best_tap, tap_cur;
  logic [5:0] win_len;

  idelay_tap_cal_if #(.DW(DW)) dif();

  // MIN_WIN=3 makes a 29..31 window (centre 30) legal for the trim test; short TIMEOUT keeps runtime low
  idelay_tap_cal #(.DW(DW), .TRAIN_PATTERN(PAT), .SETTLE_CYC(16), .SAMPLES(64),
                   .TIMEOUT(128), .MIN_WIN(3)) dut (
    .clk(clk), .rst(rst), .start(start), .step_up(step_up), .step_dn(step_dn),
    .dl(dif.master), .busy(busy), .cal_done(cal_done), .cal_fail(cal_fail),
    .best_tap(best_tap), .win_len(win_len), .tap_cur(tap_cur)
  );

  always #5 clk = ~clk;

  // delay line model
  logic [4:0] line_tap = '0;
  always @(posedge clk) begin
    if (dif.ld)      line_tap <= dif.cntvaluein;
    else if (dif.ce) line_tap <= dif.inc ? line_tap + 5'd1 : line_tap - 5'd1;
  end
  assign dif.rdy         = rdy_q;
  assign dif.cntvalueout = line_tap;
  assign dif.din_vld     = vld_en;
  assign dif.din         = mask[line_tap] ? PAT : ~PAT;

  // strobe monitor: sweep loads must count 0,1,2,... from each accepted start
  int         ld_cnt = 0, ce_cnt = 0, seq_next = 0, seq_err = 0, both_err = 0;
  logic [4:0] last_ld = '0;
  logic       last_inc = 1'b0;
  always @(negedge clk) begin
    if (start && !busy) seq_next = 0;
    if (dif.ld) begin
      ld_cnt++;
      last_ld = dif.cntvaluein;
      if (busy) begin
        if (int'(dif.cntvaluein) != seq_next) seq_err++;
        seq_next++;
      end
    end
    if (dif.ce) begin
      ce_cnt++;
      last_inc = dif.inc;
    end
    if (dif.ld && dif.ce) both_err++;
  end

  int checks = 0, errors = 0;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(string nm);
    int n = 0;
    while (!cal_done && n < 10000) begin
      cyc(1);
      n++;
    end
    chk({nm, "_done"}, int'(cal_done), 1);
  endtask

  task automatic step(bit up, bit dn, int hold);
    @(posedge clk); #1 step_up = up; step_dn = dn;
    repeat (hold) @(posedge clk);
    #1 step_up = 1'b0; step_dn = 1'b0;
    cyc(3);
  endtask

  typedef struct {
    string       nm;
    logic [31:0] m;
    bit          vld;
    int          best;
    int          len;
    bit          fail;
  } vec_t;

  function automatic logic [31:0] rng(int lo, int hi);
    logic [31:0] r = '0;
    for (int i = lo; i <= hi; i++) r[i] = 1'b1;
    return r;
  endfunction

  function automatic vec_t mkv(string nm, logic [31:0] m, bit vld, int best, int len, bit fail);
    vec_t r;
    r.nm = nm; r.m = m; r.vld = vld; r.best = best; r.len = len; r.fail = fail;
    return r;
  endfunction

  vec_t vt[7];

  initial begin
    int ld0, se0, ce0, n;
    vt[0] = mkv("all_pass", rng(0, 31), 1'b1, 15, 32, 1'b0);
    vt[1] = mkv("win10_19", rng(10, 19), 1'b1, 14, 10, 1'b0);
    vt[2] = mkv("tie_first", rng(3, 8) | rng(20, 25), 1'b1, 5, 6, 1'b0);
    vt[3] = mkv("wider_2nd", rng(2, 4) | rng(20, 27), 1'b1, 23, 8, 1'b0);
    vt[4] = mkv("no_vld", rng(0, 31), 1'b0, 0, 0, 1'b1);
    vt[5] = mkv("short_win", rng(5, 6), 1'b1, 0, 2, 1'b1);
    vt[6] = mkv("edge_win", rng(29, 31), 1'b1, 30, 3, 1'b0);

    // reset state
    cyc(3);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(cal_done), 0);
    chk("rst_fail", int'(cal_fail), 0);
    chk("rst_best", int'(best_tap), 0);
    chk("rst_len", int'(win_len), 0);
    chk("rst_tapcur", int'(tap_cur), 0);
    chk("rst_ld", int'(dif.ld), 0);
    chk("rst_ce", int'(dif.ce), 0);
    chk("rst_inc", int'(dif.inc), 0);
    chk("rst_cntin", int'(dif.cntvaluein), 0);
    rst = 1'b0;

    // start before rdy must be ignored
    pulse_start();
    cyc(4);
    chk("nordy_busy", int'(busy), 0);
    rdy_q = 1'b1;
    cyc(2);

    foreach (vt[i]) begin
      mask = vt[i].m;
      vld_en = vt[i].vld;
      ld0 = ld_cnt;
      se0 = seq_err;
      pulse_start();
      wait_done(vt[i].nm);
      cyc(3);
      chk({vt[i].nm, "_best"}, int'(best_tap), vt[i].best);
      chk({vt[i].nm, "_len"}, int'(win_len), vt[i].len);
      chk({vt[i].nm, "_fail"}, int'(cal_fail), int'(vt[i].fail));
      chk({vt[i].nm, "_busy"}, int'(busy), 0);
      chk({vt[i].nm, "_tapcur"}, int'(tap_cur), vt[i].best);
      chk({vt[i].nm, "_ldcnt"}, ld_cnt - ld0, 33);
      chk({vt[i].nm, "_apply_ld"}, int'(last_ld), vt[i].best);
      chk({vt[i].nm, "_seq"}, seq_err - se0, 0);
      chk({vt[i].nm, "_line"}, int'(line_tap), vt[i].best);
      chk({vt[i].nm, "_tapmis"}, int'(dif.tap_mis), 0);
    end

    // trim from best_tap=30
    ce0 = ce_cnt;
    step(1'b1, 1'b0, 1);
    chk("up1_ce", ce_cnt - ce0, 1);
    chk("up1_inc", int'(last_inc), 1);
    chk("up1_tap", int'(tap_cur), 31);
    step(1'b1, 1'b0, 1);
    step(1'b1, 1'b0, 1);
    chk("up_lim_ce", ce_cnt - ce0, 1);
    chk("up_lim_tap", int'(tap_cur), 31);
    step(1'b0, 1'b1, 1);
    chk("dn_ce", ce_cnt - ce0, 2);
    chk("dn_inc", int'(last_inc), 0);
    chk("dn_tap", int'(tap_cur), 30);
    step(1'b1, 1'b1, 1);
    chk("both_ce", ce_cnt - ce0, 2);
    chk("both_tap", int'(tap_cur), 30);
    step(1'b0, 1'b1, 2);
    chk("hold_ce", ce_cnt - ce0, 3);
    chk("hold_tap", int'(tap_cur), 29);
    chk("hold_line", int'(line_tap), 29);

    // rdy loss in DONE clears the done level
    rdy_q = 1'b0;
    cyc(2);
    chk("abort_done_lvl", int'(cal_done), 0);
    rdy_q = 1'b1;
    cyc(2);

    // rdy loss mid-sweep at tap 12, with an ignored start while busy
    mask = rng(0, 31);
    vld_en = 1'b1;
    se0 = seq_err;
    pulse_start();
    cyc(300);
    pulse_start();
    n = 0;
    while (!(busy && last_ld == 5'd12) && n < 5000) begin
      cyc(1);
      n++;
    end
    chk("reach_tap12", int'(last_ld), 12);
    chk("busy_start_ign", seq_err - se0, 0);
    rdy_q = 1'b0;
    ld0 = ld_cnt;
    cyc(6);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(cal_done), 0);
    chk("abort_fail", int'(cal_fail), 0);
    chk("abort_no_ld", ld_cnt - ld0, 0);
    rdy_q = 1'b1;
    cyc(2);
    ld0 = ld_cnt;
    se0 = seq_err;
    pulse_start();
    wait_done("restart");
    cyc(3);
    chk("restart_seq", seq_err - se0, 0);
    chk("restart_ldcnt", ld_cnt - ld0, 33);
    chk("restart_best", int'(best_tap), 15);
    chk("restart_len", int'(win_len), 32);
    chk("ld_ce_overlap", both_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/idelay_tap_cal.md
Name: idelay_tap_cal

Overview:
Calibration initiator for the IDELAYE2 (VAR_LOAD) tap-delay wrapper; it drives ld/cntvaluein/ce/inc and reads back rdy/cntvalueout.
- Sweeps all 32 taps and checks the deserialized delayed data against a known training word at each tap.
- Finds the widest contiguous passing window and loads its centre tap.
- After calibration, allows single-tap runtime trim.
- Sits between the delay-line wrapper and the receive datapath, in the same 200 MHz domain.

Parameters:
- DW, 8, width of the deserialized data word under test
- TRAIN_PATTERN, 8'hA5, expected word (DW bits) for a passing sample
- SETTLE_CYC, 16, wait cycles after each tap load before sampling (≥1)
- SAMPLES, 64, valid words compared per tap
- TIMEOUT, 1024, max cycles in CHECK before the tap is declared failing
- MIN_WIN, 4, minimum passing-window length for success

Ports:
- clk  in  1  200 MHz clock shared with the delay wrapper
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle pulse; begins calibration when idle or done
- rdy  in  1  IDELAYCTRL ready
- cntvalueout  in  5  tap readback from the delay line
- din_vld  in  1  din is valid this cycle
- din  in  DW  deserialized delayed data
- step_up  in  1  post-calibration +1 tap request
- step_dn  in  1  post-calibration −1 tap request
- ld  out  1  load strobe to the delay line
- cntvaluein  out  5  tap value to load
- ce  out  1  increment/decrement enable
- inc  out  1  direction (1 = up)
- busy  out  1  calibration in progress
- cal_done  out  1  calibration finished (level)
- cal_fail  out  1  best window < MIN_WIN (level, valid with cal_done)
- best_tap  out  5  applied centre tap
- win_len  out  6  best window length (0..32)
- tap_cur  out  5  tap currently applied

Behaviour:
- Reset values: all outputs 0. FSM in WAIT_RDY. All counters and window registers cleared.
- States: WAIT_RDY, IDLE, LOAD, SETTLE, CHECK, EVAL, FINAL, APPLY, DONE.
- WAIT_RDY → IDLE once rdy=1.
- In any state except WAIT_RDY, rdy=0 → WAIT_RDY next cycle. This aborts the sweep, clears busy, cal_done, cal_fail and the window registers, and keeps ld=0.
- IDLE / DONE + start → LOAD with tap=0. Window registers are cleared and busy=1. start while busy is ignored.
- LOAD:
  - ld=1 for exactly one cycle, with cntvaluein=tap.
  - → SETTLE.
- SETTLE:
  - Count SETTLE_CYC cycles; din is ignored.
  - → CHECK.
- CHECK:
  - Each din_vld compares din with TRAIN_PATTERN; any mismatch sets the tap's fail flag.
  - Leave after SAMPLES valid words → EVAL.
  - If TIMEOUT cycles elapse in CHECK first: mark the tap failing → EVAL.
- EVAL (1 cycle):
  - On pass: if cur_len==0 then cur_start=tap; cur_len++.
  - On fail: if cur_len>best_len, copy cur into best; then cur_len=0.
  - Replacement is strictly greater, so ties keep the earliest window.
  - tap==31 → FINAL; otherwise tap++ → LOAD.
- FINAL:
  - Apply the same close-out comparison to the open window.
  - centre = best_start + ((best_len−1)>>1), floor. Arithmetic is 6-bit; the result is truncated to 5 bits and cannot exceed 31.
  - If best_len < MIN_WIN: cal_fail=1 and centre=0.
- APPLY:
  - ld=1 for one cycle with cntvaluein=centre.
  - best_tap=centre, win_len=best_len, tap_cur=centre.
  - → DONE, setting cal_done=1 and busy=0.
- Trim (DONE only):
  - step_up with tap_cur<31 → ce=1, inc=1 for one cycle; tap_cur++.
  - step_dn with tap_cur>0 → ce=1, inc=0; tap_cur−−.
  - At the limits the request is ignored (no wrap, no ce).
  - Simultaneous step_up and step_dn → ignored.
  - Steps are accepted at most every 2 cycles: the cycle after a ce pulse ignores steps.
- ce/inc are 0 in every other state. ld and ce are never asserted in the same cycle.
- tap_cur also tracks the swept tap during LOAD. cntvalueout is used only for a debug compare, with no functional effect.
- The integrator ties ldpipeen and reg_rst of the delay wrapper to 0.

Decomposition:
- Shared package holds:
  - the FSM state enum (idelay_cal_state_t);
  - TAP_W=5 and TAP_MAX=31 constants;
  - the window record typedef (start[4:0], len[5:0]).
- Natural sub-module: idelay_win_track, the EVAL/FINAL window bookkeeping and centre computation (pure sequential datapath, clear/update/close inputs).

Test Plan:
- All-pass: din always = TRAIN_PATTERN → 32 ld pulses during the sweep, then APPLY with cntvaluein=15; win_len=32, cal_done=1, cal_fail=0.
- Window at taps 10..19 (mismatch elsewhere) → best_tap=14, win_len=10.
- Two windows, 3..8 and 20..25 (equal length 6) → earliest kept, best_tap=5. Windows 2..4 and 20..27 → best_tap=23, win_len=8.
- No din_vld at all → every tap times out; win_len=0, cal_fail=1, best_tap=0, cal_done=1.
- rdy dropped at tap 12 → WAIT_RDY, busy=0; on rdy return plus start, the sweep restarts from ld with cntvaluein=0.
- Trim: after best_tap=30, step_up ×3 (spaced) → one ce/inc=1 pulse, tap_cur=31, the rest ignored. Then step_dn → ce=1, inc=0, tap_cur=30.
